// File: rtl/instr_issue_unit.sv
// Program buffer and in-order instruction issuer for the fetch stage.
// Optional: define ISSUE_LOOP_EN to wrap issue back to entry 0 while run stays high.
module instr_issue_unit #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clock_pulse,
    input  logic          resetn,
    input  logic          load_en,
    input  logic          enc_mode,
    input  logic [2:0]    enc_opcode,
    input  logic [1:0]    enc_rega,
    input  logic [1:0]    enc_regb,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic          run,
    output logic [7:0]    instr_out,
    output logic          instr_valid,
    input  logic          instr_ready,
    output logic [AW-1:0] pc,
    output logic [AW:0]   count,
    output logic          halted,
    output logic          err_illegal,
    output logic          err_ovf
);

    typedef enum logic [1:0] {IDLE, LOAD, ISSUE, DONE} state_t;

    localparam logic [2:0]  OPC_ADD    = 3'b001;
    localparam logic [2:0]  OPC_INC    = 3'b011;
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    state_t        state, state_nx;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] pc_nx;
    logic [AW:0]   count_nx;
    logic [7:0]    instr_out_nx;
    logic          wr_ready_nx, instr_valid_nx, halted_nx, err_illegal_nx, err_ovf_nx;
    logic          wr_en;

    logic [7:0] wr_word;
    logic       opc_legal, full, last, handshake;

    assign wr_word   = {enc_mode, enc_opcode, enc_rega, enc_regb};
    assign opc_legal = (enc_opcode == OPC_ADD) || (enc_opcode == OPC_INC);
    assign full      = (count == FULL_COUNT);
    assign last      = ({1'b0, pc} == count - 1'b1);
    assign handshake = instr_valid && instr_ready;

    always_ff @(posedge clock_pulse or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            pc          <= '0;
            count       <= '0;
            wr_ready    <= 1'b0;
            instr_out   <= '0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
            err_illegal <= 1'b0;
            err_ovf     <= 1'b0;
        end else begin
            // NOTE: state uses non-blocking assignment so every register samples pre-edge values.
            state       <= state_nx;
            pc          <= pc_nx;
            count       <= count_nx;
            wr_ready    <= wr_ready_nx;
            instr_out   <= instr_out_nx;
            instr_valid <= instr_valid_nx;
            halted      <= halted_nx;
            err_illegal <= err_illegal_nx;
            err_ovf     <= err_ovf_nx;
        end
    end

    // NOTE: the buffer is deliberately not reset; entries at or above count are simply unused.
    always_ff @(posedge clock_pulse) begin
        if (wr_en) mem[count[AW-1:0]] <= wr_word;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_nx       = state;
        pc_nx          = pc;
        count_nx       = count;
        wr_ready_nx    = 1'b0;
        instr_out_nx   = instr_out;
        instr_valid_nx = instr_valid;
        halted_nx      = halted;
        err_illegal_nx = err_illegal;
        err_ovf_nx     = err_ovf;
        wr_en          = 1'b0;

        unique case (state)
            IDLE: begin
                instr_valid_nx = 1'b0;
                if (load_en) begin
                    state_nx    = LOAD;
                    count_nx    = '0;
                    wr_ready_nx = 1'b1;
                end else if (run && count != '0) begin
                    state_nx       = ISSUE;
                    pc_nx          = '0;
                    instr_out_nx   = mem[0];
                    instr_valid_nx = 1'b1;
                end
            end
            LOAD: begin
                if (wr_valid) begin
                    if (full)            err_ovf_nx     = 1'b1;
                    else if (!opc_legal) err_illegal_nx = 1'b1;
                    else begin
                        wr_en    = 1'b1;
                        count_nx = count + 1'b1;
                    end
                end
                wr_ready_nx = load_en && (count_nx < FULL_COUNT);
                if (!load_en) state_nx = IDLE;
            end
            ISSUE: begin
                // The presented word only changes on a handshake; run is honoured afterwards.
                if (handshake) begin
                    if (last) begin
`ifdef ISSUE_LOOP_EN
                        pc_nx = '0;
                        if (run) begin
                            instr_out_nx = mem[0];
                        end else begin
                            state_nx       = IDLE;
                            instr_valid_nx = 1'b0;
                        end
`else
                        state_nx       = DONE;
                        instr_valid_nx = 1'b0;
                        halted_nx      = 1'b1;
`endif
                    end else if (run) begin
                        pc_nx        = pc + 1'b1;
                        instr_out_nx = mem[pc + 1'b1];
                    end else begin
                        state_nx       = IDLE;
                        pc_nx          = '0;
                        instr_valid_nx = 1'b0;
                    end
                end
            end
            DONE: begin
                instr_valid_nx = 1'b0;
                if (!run) begin
                    state_nx  = IDLE;
                    halted_nx = 1'b0;
                    pc_nx     = '0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_instr_issue_unit.sv
// Self-checking bench for instr_issue_unit: directed scenarios plus randomized
// programs checked against a queue-based reference model.
module tb_instr_issue_unit;

    localparam int DEPTH = 8;
    localparam int AW    = 3;
`ifdef ISSUE_LOOP_EN
    localparam int REPS = 2;
`else
    localparam int REPS = 1;
`endif

    logic          clock_pulse, resetn;
    logic          load_en, enc_mode, wr_valid, wr_ready, run;
    logic [2:0]    enc_opcode;
    logic [1:0]    enc_rega, enc_regb;
    logic [7:0]    instr_out;
    logic          instr_valid, instr_ready;
    logic [AW-1:0] pc;
    logic [AW:0]   count;
    logic          halted, err_illegal, err_ovf;

    instr_issue_unit #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clock_pulse (clock_pulse),
        .resetn      (resetn),
        .load_en     (load_en),
        .enc_mode    (enc_mode),
        .enc_opcode  (enc_opcode),
        .enc_rega    (enc_rega),
        .enc_regb    (enc_regb),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .run         (run),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pc          (pc),
        .count       (count),
        .halted      (halted),
        .err_illegal (err_illegal),
        .err_ovf     (err_ovf)
    );

    initial clock_pulse = 1'b0;
    always #5 clock_pulse = ~clock_pulse;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: the stored program in order, plus the sticky flags.
    int stim[$];
    int prog[$];
    bit exp_ill, exp_ovf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock_pulse);
        #1;
    endtask

    function automatic int make_word(int mode, int opc, int ra, int rb);
        return mode * 128 + opc * 16 + ra * 4 + rb;
    endfunction

    function automatic int rand_word(int illegal_pct);
        int opc;
        if ($urandom_range(99) < illegal_pct) begin
            opc = $urandom_range(7);
        end else begin
            opc = ($urandom_range(1) == 1) ? 3 : 1;
        end
        return make_word($urandom_range(1), opc, $urandom_range(3), $urandom_range(3));
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_wr_ready"}, wr_ready, 0);
        check({tag, "_instr_out"}, instr_out, 0);
        check({tag, "_instr_valid"}, instr_valid, 0);
        check({tag, "_pc"}, pc, 0);
        check({tag, "_count"}, count, 0);
        check({tag, "_halted"}, halted, 0);
        check({tag, "_err_illegal"}, err_illegal, 0);
        check({tag, "_err_ovf"}, err_ovf, 0);
    endtask

    task automatic do_reset();
        resetn = 1'b0; load_en = 1'b0; wr_valid = 1'b0; run = 1'b0; instr_ready = 1'b0;
        enc_mode = 1'b0; enc_opcode = '0; enc_rega = '0; enc_regb = '0;
        #12;
        resetn = 1'b1;
        prog.delete();
        exp_ill = 1'b0;
        exp_ovf = 1'b0;
        tick();
    endtask

    // Loads the words in stim as one session; the model keeps legal words while room remains.
    task automatic load_stim();
        logic [7:0] w;
        int opc;
        load_en = 1'b1;
        tick();
        prog.delete();
        check("load_entry_ready", wr_ready, 1);
        check("load_entry_count", count, 0);
        foreach (stim[i]) begin
            w = 8'(stim[i]);
            opc = (stim[i] / 16) % 8;
            enc_mode = w[7]; enc_opcode = w[6:4]; enc_rega = w[3:2]; enc_regb = w[1:0];
            wr_valid = 1'b1;
            tick();
            if (prog.size() == DEPTH)      exp_ovf = 1'b1;
            else if (opc != 1 && opc != 3) exp_ill = 1'b1;
            else                           prog.push_back(stim[i]);
            check("load_count", count, prog.size());
            check("load_ready", wr_ready, prog.size() < DEPTH);
            check("load_err_illegal", err_illegal, exp_ill);
            check("load_err_ovf", err_ovf, exp_ovf);
        end
        wr_valid = 1'b0;
        load_en = 1'b0;
        tick();
        check("load_exit_ready", wr_ready, 0);
        check("load_exit_count", count, prog.size());
    endtask

    // Issues the stored program with random back-pressure and checks order, pc and halt.
    task automatic issue_prog(input int stall_pct);
        int n = prog.size();
        int idx = 0;
        int budget = 0;
        run = 1'b1;
        instr_ready = 1'b0;
        tick();
        while (idx < n * REPS && budget < 1000) begin
            check("issue_valid", instr_valid, 1);
            check("issue_word", instr_out, prog[idx % n]);
            check("issue_pc", pc, idx % n);
            check("issue_halted", halted, 0);
            instr_ready = ($urandom_range(99) >= stall_pct);
            tick();
            if (instr_ready) idx++;
            budget++;
        end
        check("issue_budget", budget < 1000, 1);
`ifdef ISSUE_LOOP_EN
        check("loop_wrap_valid", instr_valid, 1);
        check("loop_wrap_word", instr_out, prog[0]);
        check("loop_halted", halted, 0);
        run = 1'b0;
        instr_ready = 1'b1;
        tick();
`else
        check("done_halted", halted, 1);
        check("done_valid", instr_valid, 0);
        run = 1'b0;
        tick();
`endif
        instr_ready = 1'b0;
        check("idle_valid", instr_valid, 0);
        check("idle_pc", pc, 0);
        check("idle_halted", halted, 0);
    endtask

    initial begin
        do_reset();
        check_all_zero("reset");

        // Directed ADD/INC program: 8'h91, 8'hB5, issued back to back.
        stim = {make_word(1, 1, 0, 1), make_word(1, 3, 1, 1)};
        load_stim();
        check("directed_count", count, 2);
        issue_prog(0);

        // Back-pressure: word and pc hold; dropping run leaves only after the handshake.
        run = 1'b1;
        tick();
        repeat (3) begin
            check("hold_valid", instr_valid, 1);
            check("hold_word", instr_out, 8'h91);
            check("hold_pc", pc, 0);
            tick();
        end
        run = 1'b0;
        tick();
        check("abandon_still_valid", instr_valid, 1);
        check("abandon_still_word", instr_out, 8'h91);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        check("abandon_valid", instr_valid, 0);
        check("abandon_pc", pc, 0);

        // Illegal opcode 3'b010 is dropped between two legal words.
        stim = {8'h91, make_word(0, 2, 3, 3), 8'hB5};
        load_stim();
        check("illegal_flag", err_illegal, 1);
        issue_prog(25);

        // Empty program: run leaves the unit idle.
        stim = {make_word(1, 7, 0, 0)};
        load_stim();
        run = 1'b1;
        tick();
        tick();
        check("empty_valid", instr_valid, 0);
        check("empty_halted", halted, 0);
        run = 1'b0;
        tick();

        // Nine legal words into eight entries: ninth dropped and flagged.
        stim.delete();
        repeat (DEPTH + 1) stim.push_back(rand_word(0));
        load_stim();
        check("ovf_flag", err_ovf, 1);
        check("ovf_count", count, DEPTH);
        issue_prog(30);

        // Randomized programs with mixed legal/illegal words and random stalls.
        for (int r = 0; r < 6; r++) begin
            stim.delete();
            repeat ($urandom_range(DEPTH, 1)) stim.push_back(rand_word(20));
            load_stim();
            if (prog.size() != 0) issue_prog(30);
        end

        // Asynchronous reset mid-ISSUE at pc=1.
        stim = {8'h91, 8'hB5, make_word(0, 1, 2, 3)};
        load_stim();
        run = 1'b1;
        instr_ready = 1'b1;
        tick();
        tick();
        instr_ready = 1'b0;
        check("pre_reset_pc", pc, 1);
        check("pre_reset_word", instr_out, 8'hB5);
        #2;
        resetn = 1'b0;
        #1;
        check_all_zero("async_reset");
        #1;
        resetn = 1'b1;
        prog.delete();
        exp_ill = 1'b0;
        exp_ovf = 1'b0;
        tick();
        tick();
        check("post_reset_valid", instr_valid, 0);
        check("post_reset_count", count, 0);
        run = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
